// File: rtl/usb_pe_out_ctrl_if.sv
// Token, receive, FIFO-fill and handshake signals around the USB OUT/SETUP engine.
// The slave modport is the engine itself; master is the surrounding protocol engine.
interface usb_pe_out_ctrl_if #(
  parameter int unsigned ENDPOINTS = 4
);
  logic                 usbResetDetected;
  logic                 ackUsbResetDetect;
  logic                 tokenValid;
  logic [3:0]           tokenPid;
  logic [3:0]           tokenEp;
  logic [ENDPOINTS-1:0] epStall;
  logic [ENDPOINTS-1:0] toggleClear;
  logic                 busy;
  logic                 rxAcceptNewData;
  logic [7:0]           rxData;
  logic                 rxIsLastByte;
  logic                 rxDataValid;
  logic                 keepPacket;
  logic [ENDPOINTS-1:0] fifoWriteEn;
  logic [7:0]           fifoData;
  logic [ENDPOINTS-1:0] fifoFull;
  logic [ENDPOINTS-1:0] fillTransDone;
  logic                 fillTransSuccess;
  logic                 hsValid;
  logic [3:0]           hsPid;
  logic                 hsAccept;

  modport slave (
    input  usbResetDetected, tokenValid, tokenPid, tokenEp, epStall, toggleClear,
    input  rxData, rxIsLastByte, rxDataValid, keepPacket, fifoFull, hsAccept,
    output ackUsbResetDetect, busy, rxAcceptNewData, fifoWriteEn, fifoData,
    output fillTransDone, fillTransSuccess, hsValid, hsPid
  );

  modport master (
    output usbResetDetected, tokenValid, tokenPid, tokenEp, epStall, toggleClear,
    output rxData, rxIsLastByte, rxDataValid, keepPacket, fifoFull, hsAccept,
    input  ackUsbResetDetect, busy, rxAcceptNewData, fifoWriteEn, fifoData,
    input  fillTransDone, fillTransSuccess, hsValid, hsPid
  );
endinterface

// File: rtl/usb_pe_out_ctrl.sv
// USB OUT/SETUP transaction engine: receives a data packet into a per-endpoint FIFO,
// tracks DATA0/DATA1 per endpoint, commits or rolls back, and requests ACK/NAK/STALL.
module usb_pe_out_ctrl #(
  parameter int unsigned          ENDPOINTS        = 4,
  parameter int unsigned          MAX_PACKET_BYTES = 64,
  parameter int unsigned          TIMEOUT_CYCLES   = 80,
  parameter logic [ENDPOINTS-1:0] ISO_MASK         = '0
) (
  input logic              clk48,
  input logic              rst,
  usb_pe_out_ctrl_if.slave bus_io
);
  localparam int unsigned EpW  = (ENDPOINTS > 1) ? $clog2(ENDPOINTS) : 1;
  localparam int unsigned CntW = $clog2(MAX_PACKET_BYTES + 1) + 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax   = CntW'(MAX_PACKET_BYTES);
  localparam logic [TmrW-1:0] TmrMax   = TmrW'(TIMEOUT_CYCLES);
  localparam logic [3:0]      PidOut   = 4'b0001;
  localparam logic [3:0]      PidSetup = 4'b1101;
  localparam logic [3:0]      PidAck   = 4'b0010;
  localparam logic [3:0]      PidNak   = 4'b1010;
  localparam logic [3:0]      PidStall = 4'b1110;

  typedef enum logic [2:0] {
    StIdle, StAwaitPid, StReceive, StDrain, StDecide, StHandshake
  } state_e;

  state_e               state_q, state_d;
  logic [EpW-1:0]       ep_q, ep_d;
  logic                 is_setup_q, is_setup_d;
  logic [TmrW-1:0]      timer_q, timer_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 drop_q, drop_d;
  logic                 ovf_q, ovf_d;
  logic                 pid_tog_q, pid_tog_d;
  logic                 keep_q, keep_d;
  logic [3:0]           hs_pid_q, hs_pid_d;
  logic [ENDPOINTS-1:0] toggle_q, toggle_d;

  logic                 rx_accept, xfer, pid_ok, last;
  logic                 stall_app, mismatch, iso, full, excess, drop_now;
  logic [CntW-1:0]      cnt_inc;
  logic [TmrW-1:0]      timer_inc;
  logic [ENDPOINTS-1:0] ep_oh, fifo_we, done;
  logic                 succ;

  assign rx_accept = (state_q == StAwaitPid) || (state_q == StReceive) || (state_q == StDrain);

  always_comb begin
    state_d    = state_q;
    ep_d       = ep_q;
    is_setup_d = is_setup_q;
    timer_d    = timer_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    ovf_d      = ovf_q;
    pid_tog_d  = pid_tog_q;
    keep_d     = keep_q;
    hs_pid_d   = hs_pid_q;
    toggle_d   = toggle_q;
    fifo_we    = '0;
    done       = '0;
    succ       = 1'b0;
    ep_oh      = '0;
    ep_oh[ep_q] = 1'b1;

    xfer      = rx_accept && bus_io.rxDataValid;
    last      = bus_io.rxIsLastByte;
    pid_ok    = (bus_io.rxData[7:4] == ~bus_io.rxData[3:0]) && (bus_io.rxData[2:0] == 3'b011);
    stall_app = bus_io.epStall[ep_q] && !is_setup_q;
    // SETUP always expects DATA0 regardless of the stored toggle.
    mismatch  = pid_tog_q != (is_setup_q ? 1'b0 : toggle_q[ep_q]);
    iso       = ISO_MASK[ep_q];
    full      = bus_io.fifoFull[ep_q];
    cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    excess    = cnt_inc > CntMax;
    drop_now  = drop_q || stall_app || (mismatch && !iso) || full || excess;
    timer_inc = (timer_q == TmrMax) ? timer_q : timer_q + 1'b1;

    case (state_q)
      StIdle: begin
        if (bus_io.tokenValid && (bus_io.tokenPid == PidOut || bus_io.tokenPid == PidSetup) &&
            32'(bus_io.tokenEp) < ENDPOINTS) begin
          ep_d       = bus_io.tokenEp[EpW-1:0];
          is_setup_d = bus_io.tokenPid == PidSetup;
          timer_d    = '0;
          cnt_d      = '0;
          drop_d     = 1'b0;
          ovf_d      = 1'b0;
          state_d    = StAwaitPid;
        end
      end
      StAwaitPid: begin
        timer_d = timer_inc;
        if (xfer) begin
          if (!pid_ok) begin
            state_d = last ? StIdle : StDrain;
          end else begin
            pid_tog_d = bus_io.rxData[3];
            keep_d    = bus_io.keepPacket;
            state_d   = last ? StDecide : StReceive;
          end
        end else if (timer_inc == TmrMax) begin
          state_d = StIdle;
        end
      end
      StReceive: begin
        if (xfer) begin
          cnt_d  = cnt_inc;
          drop_d = drop_now;
          if (full || excess) ovf_d = 1'b1;
          if (!drop_now) fifo_we = ep_oh;
          if (last) begin
            keep_d  = bus_io.keepPacket;
            state_d = StDecide;
          end
        end
      end
      StDrain: begin
        if (xfer && last) state_d = StIdle;
      end
      StDecide: begin
        done    = ep_oh;
        state_d = StIdle;
        if (!keep_q) begin
          succ = 1'b0;
        end else if (iso) begin
          succ = !ovf_q;
        end else if (stall_app) begin
          hs_pid_d = PidStall;
          state_d  = StHandshake;
        end else if (mismatch) begin
          // Duplicate of an already-committed packet: acknowledge but discard.
          hs_pid_d = PidAck;
          state_d  = StHandshake;
        end else if (ovf_q) begin
          hs_pid_d = PidNak;
          state_d  = StHandshake;
        end else begin
          succ     = 1'b1;
          hs_pid_d = PidAck;
          state_d  = StHandshake;
          toggle_d[ep_q] = is_setup_q ? 1'b1 : ~toggle_q[ep_q];
        end
      end
      StHandshake: begin
        if (bus_io.hsAccept) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    toggle_d = toggle_d & ~bus_io.toggleClear;

    if (bus_io.usbResetDetected) begin
      toggle_d = '0;
      state_d  = StIdle;
      fifo_we  = '0;
      succ     = 1'b0;
      done     = (state_q == StReceive || state_q == StDecide) ? ep_oh : '0;
    end
  end

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ep_q       <= '0;
      is_setup_q <= 1'b0;
      timer_q    <= '0;
      cnt_q      <= '0;
      drop_q     <= 1'b0;
      ovf_q      <= 1'b0;
      pid_tog_q  <= 1'b0;
      keep_q     <= 1'b0;
      hs_pid_q   <= '0;
      toggle_q   <= '0;
    end else begin
      state_q    <= state_d;
      ep_q       <= ep_d;
      is_setup_q <= is_setup_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
      pid_tog_q  <= pid_tog_d;
      keep_q     <= keep_d;
      hs_pid_q   <= hs_pid_d;
      toggle_q   <= toggle_d;
    end
  end

  assign bus_io.ackUsbResetDetect = bus_io.usbResetDetected;
  assign bus_io.busy              = state_q != StIdle;
  assign bus_io.rxAcceptNewData   = rx_accept;
  assign bus_io.fifoWriteEn       = fifo_we;
  assign bus_io.fifoData          = (|fifo_we) ? bus_io.rxData : 8'h00;
  assign bus_io.fillTransDone     = done;
  assign bus_io.fillTransSuccess  = succ;
  assign bus_io.hsValid           = state_q == StHandshake;
  assign bus_io.hsPid             = (state_q == StHandshake) ? hs_pid_q : 4'h0;
endmodule

// File: tb/tb_usb_pe_out_ctrl.sv
// Directed bench for usb_pe_out_ctrl: one task per scenario with hand-computed expectations.
// A second instance with endpoint 2 isochronous covers the ISO path.
module tb_usb_pe_out_ctrl;
  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidSetup = 4'b1101;
  localparam logic [3:0] PidAck   = 4'b0010;
  localparam logic [3:0] PidNak   = 4'b1010;
  localparam logic [3:0] PidStall = 4'b1110;

  logic clk48 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk48 = ~clk48;

  usb_pe_out_ctrl_if #(.ENDPOINTS(4)) bus ();
  usb_pe_out_ctrl_if #(.ENDPOINTS(4)) ibus ();

  usb_pe_out_ctrl #(
    .ENDPOINTS(4), .MAX_PACKET_BYTES(64), .TIMEOUT_CYCLES(80), .ISO_MASK(4'b0000)
  ) dut (.clk48(clk48), .rst(rst), .bus_io(bus.slave));

  usb_pe_out_ctrl #(
    .ENDPOINTS(4), .MAX_PACKET_BYTES(64), .TIMEOUT_CYCLES(80), .ISO_MASK(4'b0100)
  ) dut_iso (.clk48(clk48), .rst(rst), .bus_io(ibus.slave));

  int vectors = 0;
  int miscompares = 0;

  // Passive monitor of the main instance.
  logic [7:0] wr_data[$];
  logic [3:0] wr_en[$];
  int         done_total = 0;
  int         hs_cycles = 0;
  logic [3:0] last_done = '0;
  logic       last_succ = 1'b0;

  always @(negedge clk48) begin
    if (bus.fifoWriteEn != '0) begin
      wr_data.push_back(bus.fifoData);
      wr_en.push_back(bus.fifoWriteEn);
    end
    if (bus.fillTransDone != '0) begin
      done_total <= done_total + 1;
      last_done  <= bus.fillTransDone;
      last_succ  <= bus.fillTransSuccess;
    end
    if (bus.hsValid) hs_cycles <= hs_cycles + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk48);
    #1;
  endtask

  task automatic send_pkt(input logic [3:0] tpid, input int ep, input logic [7:0] pid_byte,
                          input int n, input logic [7:0] base, input logic keep,
                          input int full_from);
    bus.tokenValid = 1'b1;
    bus.tokenPid   = tpid;
    bus.tokenEp    = 4'(ep);
    tick();
    bus.tokenValid = 1'b0;
    for (int i = 0; i <= n; i++) begin
      bus.rxDataValid  = 1'b1;
      bus.rxData       = (i == 0) ? pid_byte : base + 8'(i - 1);
      bus.rxIsLastByte = (i == n);
      bus.keepPacket   = (i == n) ? keep : 1'b0;
      if (full_from >= 0 && i > full_from) bus.fifoFull[ep] = 1'b1;
      tick();
    end
    bus.rxDataValid  = 1'b0;
    bus.rxIsLastByte = 1'b0;
    bus.keepPacket   = 1'b0;
    bus.fifoFull     = '0;
  endtask

  // Waits (bounded) for a handshake, holds hsAccept low two cycles, then accepts it.
  task automatic finish_hs(output logic got, output logic [3:0] pid, output logic stable);
    got = 1'b0;
    pid = '0;
    stable = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk48);
      if (bus.hsValid) begin
        got = 1'b1;
        pid = bus.hsPid;
        break;
      end
    end
    if (got) begin
      repeat (2) @(negedge clk48);
      stable = bus.hsValid && (bus.hsPid === pid);
      bus.hsAccept = 1'b1;
      tick();
      bus.hsAccept = 1'b0;
    end else begin
      tick();
    end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    @(negedge clk48);
    vectors++;
    if ({bus.busy, bus.rxAcceptNewData, bus.fifoWriteEn, bus.fillTransDone, bus.fillTransSuccess,
         bus.hsValid, bus.hsPid, bus.ackUsbResetDetect, bus.fifoData} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b acc=%b we=%b done=%b hs=%b, want all 0",
               bus.busy, bus.rxAcceptNewData, bus.fifoWriteEn, bus.fillTransDone, bus.hsValid);
    end
    @(posedge clk48);
    #1 rst = 1'b0;
    @(negedge clk48);
    vectors++;
    if ({bus.busy, bus.rxAcceptNewData, bus.hsValid, ibus.busy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL post_reset_idle: busy=%b acc=%b hs=%b iso_busy=%b, want 0",
               bus.busy, bus.rxAcceptNewData, bus.hsValid, ibus.busy);
    end
    tick();
  endtask

  task automatic test_commit_and_dup();
    int w0, d0;
    logic got, stable;
    logic [3:0] pid;
    w0 = wr_data.size();
    d0 = done_total;
    send_pkt(PidOut, 1, 8'hC3, 3, 8'hA1, 1'b1, -1);
    finish_hs(got, pid, stable);
    vectors++;
    if (wr_data.size() - w0 !== 3) begin
      miscompares++;
      $display("FAIL commit_wr_count: got %0d want 3", wr_data.size() - w0);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (w0 + i >= wr_data.size() || wr_data[w0+i] !== 8'hA1 + 8'(i) ||
          wr_en[w0+i] !== 4'b0010) begin
        miscompares++;
        $display("FAIL commit_data[%0d]: got %h/%b want %h/0010", i, wr_data[w0+i],
                 wr_en[w0+i], 8'hA1 + 8'(i));
      end
    end
    vectors++;
    if (done_total - d0 !== 1 || last_done !== 4'b0010 || last_succ !== 1'b1) begin
      miscompares++;
      $display("FAIL commit_done: n=%0d mask=%b succ=%b want 1/0010/1", done_total - d0,
               last_done, last_succ);
    end
    vectors++;
    if (got !== 1'b1 || pid !== PidAck || stable !== 1'b1) begin
      miscompares++;
      $display("FAIL commit_hs: got=%b pid=%b stable=%b want 1/0010/1", got, pid, stable);
    end

    w0 = wr_data.size();
    send_pkt(PidOut, 1, 8'hC3, 3, 8'hA1, 1'b1, -1);
    finish_hs(got, pid, stable);
    vectors++;
    if (wr_data.size() - w0 !== 0 || last_done !== 4'b0010 || last_succ !== 1'b0) begin
      miscompares++;
      $display("FAIL dup_rollback: wr=%0d mask=%b succ=%b want 0/0010/0", wr_data.size() - w0,
               last_done, last_succ);
    end
    vectors++;
    if (got !== 1'b1 || pid !== PidAck) begin
      miscompares++;
      $display("FAIL dup_hs: got=%b pid=%b want 1/0010", got, pid);
    end
  endtask

  task automatic test_stall_setup();
    int w0;
    logic got, stable;
    logic [3:0] pid;
    bus.epStall = 4'b0100;
    w0 = wr_data.size();
    send_pkt(PidOut, 2, 8'hC3, 2, 8'h50, 1'b1, -1);
    finish_hs(got, pid, stable);
    vectors++;
    if (wr_data.size() - w0 !== 0 || last_done !== 4'b0100 || last_succ !== 1'b0 ||
        got !== 1'b1 || pid !== PidStall || stable !== 1'b1) begin
      miscompares++;
      $display("FAIL stall: wr=%0d mask=%b succ=%b hs=%b pid=%b want 0/0100/0/1/1110",
               wr_data.size() - w0, last_done, last_succ, got, pid);
    end
    w0 = wr_data.size();
    send_pkt(PidSetup, 2, 8'hC3, 8, 8'h60, 1'b1, -1);
    finish_hs(got, pid, stable);
    vectors++;
    if (wr_data.size() - w0 !== 8 || wr_data[w0+7] !== 8'h67 || last_done !== 4'b0100 ||
        last_succ !== 1'b1 || got !== 1'b1 || pid !== PidAck) begin
      miscompares++;
      $display("FAIL setup: wr=%0d last=%h mask=%b succ=%b pid=%b want 8/67/0100/1/0010",
               wr_data.size() - w0, wr_data[w0+7], last_done, last_succ, pid);
    end
    bus.epStall = 4'b0000;
    w0 = wr_data.size();
    send_pkt(PidOut, 2, 8'h4B, 1, 8'h70, 1'b1, -1);
    finish_hs(got, pid, stable);
    vectors++;
    if (wr_data.size() - w0 !== 1 || last_succ !== 1'b1 || pid !== PidAck) begin
      miscompares++;
      $display("FAIL after_setup_data1: wr=%0d succ=%b pid=%b want 1/1/0010",
               wr_data.size() - w0, last_succ, pid);
    end
  endtask

  task automatic test_overflow();
    int w0, d0;
    logic got, stable;
    logic [3:0] pid;
    w0 = wr_data.size();
    send_pkt(PidOut, 0, 8'hC3, 5, 8'h80, 1'b1, 2);
    finish_hs(got, pid, stable);
    vectors++;
    if (wr_data.size() - w0 !== 2 || last_done !== 4'b0001 || last_succ !== 1'b0 ||
        pid !== PidNak) begin
      miscompares++;
      $display("FAIL fifo_full: wr=%0d mask=%b succ=%b pid=%b want 2/0001/0/1010",
               wr_data.size() - w0, last_done, last_succ, pid);
    end
    w0 = wr_data.size();
    send_pkt(PidOut, 0, 8'hC3, 65, 8'h00, 1'b1, -1);
    finish_hs(got, pid, stable);
    vectors++;
    if (wr_data.size() - w0 !== 64 || last_succ !== 1'b0 || got !== 1'b1 || pid !== PidNak) begin
      miscompares++;
      $display("FAIL max_bytes: wr=%0d succ=%b pid=%b want 64/0/1010", wr_data.size() - w0,
               last_succ, pid);
    end
    w0 = wr_data.size();
    d0 = done_total;
    send_pkt(PidOut, 0, 8'hC3, 0, 8'h00, 1'b1, -1);
    finish_hs(got, pid, stable);
    vectors++;
    if (wr_data.size() - w0 !== 0 || done_total - d0 !== 1 || last_succ !== 1'b1 ||
        pid !== PidAck) begin
      miscompares++;
      $display("FAIL zlp_toggle0: wr=%0d done=%0d succ=%b pid=%b want 0/1/1/0010",
               wr_data.size() - w0, done_total - d0, last_succ, pid);
    end
  endtask

  task automatic test_timeout_and_errors();
    int w0, d0, h0;
    logic got, stable;
    logic [3:0] pid;
    d0 = done_total;
    h0 = hs_cycles;
    bus.tokenValid = 1'b1;
    bus.tokenPid   = PidOut;
    bus.tokenEp    = 4'd5;
    tick();
    bus.tokenValid = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_ep_token: busy=%b want 0", bus.busy);
    end
    bus.tokenValid = 1'b1;
    bus.tokenEp    = 4'd1;
    tick();
    bus.tokenValid = 1'b0;
    repeat (78) tick();
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_early: busy=%b want 1", bus.busy);
    end
    repeat (3) tick();
    vectors++;
    if (bus.busy !== 1'b0 || done_total - d0 !== 0 || hs_cycles - h0 !== 0) begin
      miscompares++;
      $display("FAIL timeout: busy=%b done=%0d hs=%0d want 0/0/0", bus.busy, done_total - d0,
               hs_cycles - h0);
    end
    w0 = wr_data.size();
    send_pkt(PidOut, 1, 8'hFF, 2, 8'h90, 1'b1, -1);
    finish_hs(got, pid, stable);
    vectors++;
    if (wr_data.size() - w0 !== 0 || done_total - d0 !== 0 || got !== 1'b0 ||
        bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_pid: wr=%0d done=%0d hs=%b busy=%b want 0/0/0/0", wr_data.size() - w0,
               done_total - d0, got, bus.busy);
    end
    w0 = wr_data.size();
    send_pkt(PidOut, 1, 8'h4B, 2, 8'hB0, 1'b0, -1);
    finish_hs(got, pid, stable);
    vectors++;
    if (wr_data.size() - w0 !== 2 || done_total - d0 !== 1 || last_succ !== 1'b0 ||
        got !== 1'b0) begin
      miscompares++;
      $display("FAIL crc_bad: wr=%0d done=%0d succ=%b hs=%b want 2/1/0/0", wr_data.size() - w0,
               done_total - d0, last_succ, got);
    end
  endtask

  task automatic test_usb_reset();
    logic ack, succ, got, stable;
    logic [3:0] mask, pid;
    bus.tokenValid = 1'b1;
    bus.tokenPid   = PidOut;
    bus.tokenEp    = 4'd3;
    tick();
    bus.tokenValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rxDataValid = 1'b1;
      bus.rxData      = (i == 0) ? 8'hC3 : 8'h30 + 8'(i);
      tick();
    end
    bus.rxDataValid      = 1'b0;
    bus.usbResetDetected = 1'b1;
    @(negedge clk48);
    ack  = bus.ackUsbResetDetect;
    mask = bus.fillTransDone;
    succ = bus.fillTransSuccess;
    tick();
    bus.usbResetDetected = 1'b0;
    vectors++;
    if (ack !== 1'b1 || mask !== 4'b1000 || succ !== 1'b0) begin
      miscompares++;
      $display("FAIL usb_reset_abort: ack=%b mask=%b succ=%b want 1/1000/0", ack, mask, succ);
    end
    @(negedge clk48);
    vectors++;
    if (bus.busy !== 1'b0 || bus.ackUsbResetDetect !== 1'b0) begin
      miscompares++;
      $display("FAIL usb_reset_idle: busy=%b ack=%b want 0/0", bus.busy, bus.ackUsbResetDetect);
    end
    tick();
    // Toggle 1 was DATA1; after bus reset a DATA0 packet must commit.
    send_pkt(PidOut, 1, 8'hC3, 1, 8'hD0, 1'b1, -1);
    finish_hs(got, pid, stable);
    vectors++;
    if (last_done !== 4'b0010 || last_succ !== 1'b1 || pid !== PidAck) begin
      miscompares++;
      $display("FAIL usb_reset_toggle: mask=%b succ=%b pid=%b want 0010/1/0010", last_done,
               last_succ, pid);
    end
  endtask

  task automatic test_toggle_clear();
    logic got, stable;
    logic [3:0] pid;
    bus.toggleClear = 4'b0010;
    tick();
    bus.toggleClear = 4'b0000;
    send_pkt(PidOut, 1, 8'hC3, 1, 8'hE0, 1'b1, -1);
    finish_hs(got, pid, stable);
    vectors++;
    if (last_done !== 4'b0010 || last_succ !== 1'b1 || pid !== PidAck) begin
      miscompares++;
      $display("FAIL toggle_clear: mask=%b succ=%b pid=%b want 0010/1/0010", last_done,
               last_succ, pid);
    end
  endtask

  task automatic test_iso();
    int w = 0;
    int hs = 0;
    logic [3:0] mask = '0;
    logic succ = 1'b0;
    ibus.tokenValid = 1'b1;
    ibus.tokenPid   = PidOut;
    ibus.tokenEp    = 4'd2;
    tick();
    ibus.tokenValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ibus.rxDataValid  = 1'b1;
      ibus.rxData       = (i == 0) ? 8'h4B : 8'h10 + 8'(i);
      ibus.rxIsLastByte = (i == 2);
      ibus.keepPacket   = (i == 2);
      @(negedge clk48);
      if (ibus.fifoWriteEn == 4'b0100) w++;
      tick();
    end
    ibus.rxDataValid  = 1'b0;
    ibus.rxIsLastByte = 1'b0;
    ibus.keepPacket   = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk48);
      if (ibus.fillTransDone != '0) begin
        mask = ibus.fillTransDone;
        succ = ibus.fillTransSuccess;
      end
      if (ibus.hsValid) hs++;
    end
    tick();
    vectors++;
    if (w !== 2 || mask !== 4'b0100 || succ !== 1'b1 || hs !== 0 || ibus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL iso: wr=%0d mask=%b succ=%b hs=%0d busy=%b want 2/0100/1/0/0", w, mask,
               succ, hs, ibus.busy);
    end
  endtask

  initial begin
    bus.usbResetDetected = 1'b0;
    bus.tokenValid = 1'b0;
    bus.tokenPid = '0;
    bus.tokenEp = '0;
    bus.epStall = '0;
    bus.toggleClear = '0;
    bus.rxData = '0;
    bus.rxIsLastByte = 1'b0;
    bus.rxDataValid = 1'b0;
    bus.keepPacket = 1'b0;
    bus.fifoFull = '0;
    bus.hsAccept = 1'b0;
    ibus.usbResetDetected = 1'b0;
    ibus.tokenValid = 1'b0;
    ibus.tokenPid = '0;
    ibus.tokenEp = '0;
    ibus.epStall = '0;
    ibus.toggleClear = '0;
    ibus.rxData = '0;
    ibus.rxIsLastByte = 1'b0;
    ibus.rxDataValid = 1'b0;
    ibus.keepPacket = 1'b0;
    ibus.fifoFull = '0;
    ibus.hsAccept = 1'b0;
    repeat (2) @(posedge clk48);
    test_reset();
    test_commit_and_dup();
    test_stall_setup();
    test_overflow();
    test_timeout_and_errors();
    test_usb_reset();
    test_toggle_clear();
    test_iso();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
